// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: adder_op_e opcode enum, chunk width helper, subtract decode helper.
package adder_pkg;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      ADC = 2'd2,
      SBB = 2'd3
   } adder_op_e;

   // Width of the slice each pipeline stage adds.
   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

   // SUB and SBB add the one's complement of B.
   function automatic logic op_is_sub(input adder_op_e op);
      return (op == SUB) || (op == SBB);
   endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-bit slice of the pipelined adder: combinational add with carry chaining.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline decides when results are captured.
//
// Ports:
//   a_i, b_i   operand slices (b_i is already the effective, possibly inverted, B)
//   cin_i      carry into the slice
//   sum_o      slice sum
//   cout_o     carry out of the slice MSB
//   ovf_o      signed overflow if this slice holds the operand MSB
module adder_stage #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             cin_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o
);

   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

   // Overflow: both operands share a sign and the sum sign differs from it.
   assign ovf_o = (a_i[CHUNK-1] == b_i[CHUNK-1]) & (sum_o[CHUNK-1] != a_i[CHUNK-1]);

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/sub/adc/sbb unit, one CHUNK-bit add per stage, with registered flags.
// Latency: STAGES cycles from the accepting edge to o_valid; throughput one beat per cycle.
// Backpressure: the whole pipe freezes while o_valid & ~o_ready; i_ready mirrors that advance signal.
//
// Ports:
//   clk, rst_n                       clock and synchronous active-low reset
//   i_valid/i_ready, i_a, i_b,       operand beat handshake and operands
//   i_op, i_cin                      opcode (adder_op_e) and carry-in for ADC/SBB
//   o_valid/o_ready, o_result,       result beat handshake and sum/difference
//   o_carry, o_overflow, o_zero,     registered flags for the result beat
//   o_negative
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [1:0]       i_op,
   input  logic             i_cin,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_overflow,
   output logic             o_zero,
   output logic             o_negative
);

   localparam int CHUNK = chunk_width(WIDTH, STAGES);

   if (WIDTH % STAGES != 0) begin : g_bad_split
      $error("pipelined_adder: STAGES must divide WIDTH exactly");
   end

   adder_op_e op;
   logic      advance;
   logic      cin0;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] final_sum;

   // Per-stage registers (index k = state captured after stage k).
   logic [STAGES-1:0]            vld_q;
   logic [STAGES-1:0][WIDTH-1:0] a_q;
   logic [STAGES-1:0][WIDTH-1:0] b_q;
   logic [STAGES-1:0][WIDTH-1:0] sum_q;
   logic [STAGES-1:0]            cy_q;
   logic                         ovf_q;
   logic                         zero_q;
   logic                         neg_q;

   // Per-stage inputs: stage 0 reads the ports, stage k reads register k-1.
   logic [STAGES-1:0]            vld_d;
   logic [STAGES-1:0][WIDTH-1:0] a_d;
   logic [STAGES-1:0][WIDTH-1:0] b_d;
   logic [STAGES-1:0][WIDTH-1:0] sum_d;
   logic [STAGES-1:0]            cy_d;

   logic [STAGES-1:0][CHUNK-1:0] ch_sum;
   logic [STAGES-1:0]            ch_cout;
   logic [STAGES-1:0]            ch_ovf;

   assign op      = adder_op_e'(i_op);
   assign o_valid = vld_q[STAGES-1];
   assign advance = ~o_valid | o_ready;
   assign i_ready = advance;

   always_comb begin
      b_eff = op_is_sub(op) ? ~i_b : i_b;
      case (op)
         ADD:     cin0 = 1'b0;
         SUB:     cin0 = 1'b1;
         default: cin0 = i_cin;
      endcase
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign vld_d[k] = i_valid;
         assign a_d[k]   = i_a;
         assign b_d[k]   = b_eff;
         assign sum_d[k] = '0;
         assign cy_d[k]  = cin0;
      end else begin : g_next
         assign vld_d[k] = vld_q[k-1];
         assign a_d[k]   = a_q[k-1];
         assign b_d[k]   = b_q[k-1];
         assign sum_d[k] = sum_q[k-1];
         assign cy_d[k]  = cy_q[k-1];
      end

      adder_stage #(.CHUNK(CHUNK)) u_stage (
         .a_i    (a_d[k][k*CHUNK +: CHUNK]),
         .b_i    (b_d[k][k*CHUNK +: CHUNK]),
         .cin_i  (cy_d[k]),
         .sum_o  (ch_sum[k]),
         .cout_o (ch_cout[k]),
         .ovf_o  (ch_ovf[k])
      );
   end

   // Full aligned sum entering the output register, for zero/negative flags.
   always_comb begin
      final_sum = sum_d[STAGES-1];
      final_sum[WIDTH-CHUNK +: CHUNK] = ch_sum[STAGES-1];
   end

   // Data registers only load behind a valid beat, so bubbles never disturb
   // the last result and a fresh reset keeps the outputs at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         cy_q   <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else if (advance) begin
         vld_q <= vld_d;
         for (int k = 0; k < STAGES; k++) begin
            if (vld_d[k]) begin
               a_q[k]   <= a_d[k];
               b_q[k]   <= b_d[k];
               sum_q[k] <= sum_d[k];
               sum_q[k][k*CHUNK +: CHUNK] <= ch_sum[k];
               cy_q[k]  <= ch_cout[k];
            end
         end
         if (vld_d[STAGES-1]) begin
            ovf_q  <= ch_ovf[STAGES-1];
            zero_q <= (final_sum == '0);
            neg_q  <= final_sum[WIDTH-1];
         end
      end
   end

   assign o_result   = sum_q[STAGES-1];
   assign o_carry    = cy_q[STAGES-1];
   assign o_overflow = ovf_q;
   assign o_zero     = zero_q;
   assign o_negative = neg_q;

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined integer add/subtract unit with a valid/ready handshake; the sequential successor of the ripple-carry adder.
- WIDTH is split into STAGES equal chunks. Each pipeline stage adds one chunk and registers its carry into the next stage, so the critical path is one CHUNK-bit add.
- Supports carry-in chaining for multi-precision arithmetic and produces registered carry, signed-overflow, zero and negative flags. It sits between the ALU operand mux and the ALU result bus.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STAGES, 4, number of pipeline stages; must divide WIDTH exactly (elaboration-time error otherwise). STAGES=1 gives a single registered add.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- i_valid  input  1  operand beat valid.
- i_ready  output  1  unit can accept a beat this cycle.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_op  input  2  0=ADD, 1=SUB, 2=ADC, 3=SBB.
- i_cin  input  1  carry-in, used by ADC/SBB only (for SBB: 1 = no borrow).
- o_valid  output  1  result beat valid.
- o_ready  input  1  downstream accepts the result.
- o_result  output  WIDTH  sum/difference.
- o_carry  output  1  carry out of the MSB (for SUB/SBB: 1 = no borrow).
- o_overflow  output  1  signed overflow.
- o_zero  output  1  o_result == 0.
- o_negative  output  1  o_result[WIDTH-1].

Behaviour:
- CHUNK = WIDTH/STAGES.
- Effective B: ~i_b for SUB/SBB, i_b for ADD/ADC.
- Stage-0 carry-in: 0 for ADD, 1 for SUB, i_cin for ADC/SBB.
- Stage k (0..STAGES-1):
  - adds chunk k of A and effective B with the carry registered by stage k-1;
  - registers its CHUNK-bit sum, its carry and a valid bit.
- Skew registers: upper, not-yet-added operand chunks travel with the beat. Lower, already-computed sum chunks also travel with it, so all sum bits align at the output register.
- Latency: exactly STAGES cycles from the accepting edge (i_valid & i_ready) to o_valid, with no stall. Throughput: one beat per cycle.
- Stall model: advance = ~o_valid | o_ready, and i_ready = advance.
  - When advance=0, every stage register holds (valid and data).
  - No beat is dropped, duplicated or reordered.
  - Bubbles (valid=0) propagate but do not compact while stalled.
- o_* data and flags are held stable while o_valid=1 and o_ready=0.
- Flag rules, computed in the final stage from registered MSBs:
  - o_overflow = (A[MSB] == Beff[MSB]) & (sum[MSB] != A[MSB]).
  - o_carry = final-stage carry out.
  - o_zero and o_negative are derived from the aligned o_result.
- Wrap-around: results are modulo 2^WIDTH and never saturate.
- i_valid=0 while i_ready=1: a bubble enters stage 0. i_a, i_b, i_op and i_cin are don't-care.
- Reset:
  - rst_n=0 sampled at a rising edge clears all valid bits, o_result, o_carry, o_overflow, o_zero and o_negative to 0. i_ready is 1 whenever o_valid=0.
  - Reset mid-operation discards all in-flight beats. No stale result appears after rst_n returns high.
- Inputs are sampled only on accepting edges. Changing them while i_valid & ~i_ready has no effect.

Decomposition:
- Shared package adder_pkg:
  - typedef enum logic [1:0] adder_op_e {ADD, SUB, ADC, SBB};
  - localparam helpers for CHUNK.
- One natural sub-module, adder_stage (parameter CHUNK): combinational CHUNK-bit add with carry in/out and an MSB tap for overflow. It is instantiated STAGES times in a generate loop.
- Pipeline and skew registers stay in pipelined_adder.

Test Plan (WIDTH=32, STAGES=4):
- ADD 0x7FFFFFFF + 0x00000001 -> 4 cycles later o_result=0x80000000, o_overflow=1, o_carry=0, o_negative=1, o_zero=0.
- ADD 0xFFFFFFFF + 0x00000001 -> o_result=0x00000000, o_carry=1, o_zero=1, o_overflow=0; this checks carry propagation through all 4 stages.
- SUB 5 - 5 -> o_result=0, o_zero=1, o_carry=1. SUB 3 - 5 -> o_result=0xFFFFFFFE, o_carry=0, o_negative=1.
- ADC i_cin=1, 0x0000FFFF + 0x00000000 -> 0x00010000. SBB i_cin=0, 0x10 - 0x01 -> 0x0E.
- Stream 8 back-to-back ADDs (k + 1, k=0..7) with o_ready=0 on cycles 5-7. Required:
  - i_ready=0 exactly while o_valid & ~o_ready;
  - outputs 1..8 in order, none lost or duplicated;
  - o_* stable during the stall.
- Accept 3 beats, then drive rst_n=0 for one edge -> o_valid=0 and all outputs 0 on the next cycle. No result emerges in the 6 cycles after release without new input.
